// File: rtl/ex_wb_stage.sv
// Execute/writeback pipeline register: captures the ALU writeback and maintains
// the PSW flags {V,N,Z,C}; the registered carry feeds the ALU carry input.
module ex_wb_stage #(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [40:0]          enable,
  input  logic                 byte_op,
  input  logic [DATA_W-1:0]    a,
  input  logic [DATA_W-1:0]    b,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic [REG_IDX_W-1:0] dst_in,
  input  logic                 psw_load,
  input  logic [3:0]           psw_in,
  input  logic [3:0]           cc_set,
  input  logic [3:0]           cc_clr,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_dst,
  output logic [DATA_W-1:0]    wb_data,
  output logic [3:0]           psw,
  output logic                 carry_out
);

  logic op_add, op_addc, op_sub, op_subc, op_dadd, op_cmp, op_logic;
  logic arith, subtract, alu_op, writes;
  logic [DATA_W-1:0] bp, data_next;
  logic cin, z, n, a_m, b_m, v_arith, c_arith, dc, dc_byte;
  logic [DATA_W:0] sum_w;
  logic [8:0] sum_b;
  logic [4:0] dsum;
  logic [3:0] flags_alu;
  logic unused_enable;

  assign op_add   = enable[9];
  assign op_addc  = enable[10];
  assign op_sub   = enable[11];
  assign op_subc  = enable[12];
  assign op_dadd  = enable[13];
  assign op_cmp   = enable[14];
  assign op_logic = |enable[20:15];
  assign unused_enable = ^{enable[40:21], enable[8:0]};

  assign arith    = op_add | op_addc | op_sub | op_subc | op_cmp;
  assign subtract = op_sub | op_subc | op_cmp;
  assign alu_op   = arith | op_dadd | op_logic;
  assign writes   = in_valid & ((|enable[13:9]) | (|enable[17:15]) | enable[19] | enable[20]);

  always_comb begin
    bp  = subtract ? ~b : b;
    cin = op_add ? 1'b0 : ((op_addc | op_subc) ? psw[0] : 1'b1);
    sum_w = {1'b0, a} + {1'b0, bp} + {{DATA_W{1'b0}}, cin};
    sum_b = {1'b0, a[7:0]} + {1'b0, bp[7:0]} + {8'b0, cin};
    z   = byte_op ? (alu_result[7:0] == 8'h00) : (alu_result == '0);
    n   = byte_op ? alu_result[7] : alu_result[15];
    a_m = byte_op ? a[7] : a[15];
    b_m = byte_op ? bp[7] : bp[15];
    v_arith = (a_m == b_m) && (n != a_m);
    c_arith = byte_op ? sum_b[8] : sum_w[DATA_W];
    data_next = byte_op ? {a[15:8], alu_result[7:0]} : alu_result;

    // Decimal carry ripples digit by digit; byte ops take the carry out of digit 1.
    dc      = psw[0];
    dc_byte = 1'b0;
    dsum    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      dsum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, dc};
      dc   = (dsum > 5'd9);
      if (i == 1) dc_byte = dc;
    end

    flags_alu = psw;
    if (arith)         flags_alu = {v_arith, n, z, c_arith};
    else if (op_dadd)  flags_alu = {psw[3], n, z, byte_op ? dc_byte : dc};
    else if (op_logic) flags_alu = {psw[3], n, z, psw[0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
      psw      <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (!stall) begin
      wb_valid <= writes;
      wb_dst   <= dst_in;
      wb_data  <= data_next;
      if (psw_load)                psw <= psw_in;
      else if (|(cc_set | cc_clr)) psw <= (psw & ~cc_clr) | cc_set;
      else if (in_valid && alu_op) psw <= flags_alu;
    end
  end

  assign carry_out = psw[0];

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed plus randomized bench for ex_wb_stage against an opcode-level flag model.
module tb_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, stall, flush, byte_op, psw_load;
  logic [40:0] enable;
  logic [15:0] a, b, alu_result;
  logic [2:0]  dst_in;
  logic [3:0]  psw_in, cc_set, cc_clr;
  logic        wb_valid, carry_out;
  logic [2:0]  wb_dst;
  logic [15:0] wb_data;
  logic [3:0]  psw;

  int cur_op;
  int vectors = 0;
  int miscompares = 0;

  logic        e_valid;
  logic [2:0]  e_dst;
  logic [15:0] e_data;
  logic [3:0]  e_psw;

  ex_wb_stage #(.DATA_W(16), .REG_IDX_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .enable(enable), .byte_op(byte_op), .a(a), .b(b), .alu_result(alu_result),
    .dst_in(dst_in), .psw_load(psw_load), .psw_in(psw_in), .cc_set(cc_set),
    .cc_clr(cc_clr), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .psw(psw), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_valid});
    chk("wb_dst", {29'b0, wb_dst}, {29'b0, e_dst});
    chk("wb_data", {16'b0, wb_data}, {16'b0, e_data});
    chk("psw", {28'b0, psw}, {28'b0, e_psw});
    chk("carry_out", {31'b0, carry_out}, {31'b0, e_psw[0]});
  endtask

  task automatic model_reset();
    e_valid = 1'b0; e_dst = '0; e_data = '0; e_psw = '0;
  endtask

  function automatic bit op_writes(input int op);
    return (op >= 9 && op <= 20 && op != 14 && op != 18);
  endfunction

  // Flags from the arithmetic definitions using plain integer math.
  function automatic logic [3:0] alu_flags(input int op, input logic [3:0] old);
    int w, mask, r, av, bv, bpv, cv, sum, v, c, nn, zz, carry, s;
    w = byte_op ? 8 : 16;
    mask = (1 << w) - 1;
    r = int'(alu_result) & mask;
    av = int'(a) & mask;
    bv = int'(b) & mask;
    zz = (r == 0) ? 1 : 0;
    nn = (r >> (w - 1)) & 1;
    v = old[3];
    c = old[0];
    case (op)
      9, 10, 11, 12, 14: begin
        bpv = (op == 11 || op == 12 || op == 14) ? (~bv & mask) : bv;
        cv  = (op == 9) ? 0 : ((op == 10 || op == 12) ? int'(old[0]) : 1);
        sum = av + bpv + cv;
        c = (sum >> w) & 1;
        v = ((((av >> (w - 1)) & 1) == ((bpv >> (w - 1)) & 1)) &&
             (nn != ((av >> (w - 1)) & 1))) ? 1 : 0;
      end
      13: begin
        carry = int'(old[0]);
        for (int d = 0; d < w / 4; d++) begin
          s = ((av >> (4 * d)) & 15) + ((bv >> (4 * d)) & 15) + carry;
          carry = (s > 9) ? 1 : 0;
        end
        c = carry;
      end
      15, 16, 17, 18, 19, 20: ;
      default: return old;
    endcase
    return {v[0], nn[0], zz[0], c[0]};
  endfunction

  task automatic model_edge();
    if (flush) e_valid = 1'b0;
    else if (!stall) begin
      e_valid = in_valid && op_writes(cur_op);
      e_dst   = dst_in;
      e_data  = byte_op ? {a[15:8], alu_result[7:0]} : alu_result;
      if (psw_load) e_psw = psw_in;
      else if ((cc_set | cc_clr) != 4'b0) e_psw = (e_psw & ~cc_clr) | cc_set;
      else if (in_valid) e_psw = alu_flags(cur_op, e_psw);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_op(input int op);
    cur_op = op;
    enable = '0;
    if (op > 0) enable[op] = 1'b1;
  endtask

  task automatic drive(input int op, input logic bop, input logic [15:0] av,
                       input logic [15:0] bv, input logic [15:0] res);
    set_op(op);
    in_valid = 1'b1; byte_op = bop; a = av; b = bv; alu_result = res;
    dst_in = 3'(op); stall = 0; flush = 0; psw_load = 0; cc_set = 0; cc_clr = 0;
  endtask

  initial begin
    in_valid = 0; stall = 0; flush = 0; byte_op = 0; psw_load = 0;
    a = 0; b = 0; alu_result = 0; dst_in = 0; psw_in = 0; cc_set = 0; cc_clr = 0;
    set_op(0);
    model_reset();
    #1 rst = 1'b1;
    #1 check_all();
    @(posedge clk); #1 check_all();
    #2 rst = 1'b0;

    drive(9, 0, 16'h7FFF, 16'h0001, 16'h8000); step();
    chk("add_ovf_data", {16'b0, wb_data}, 32'h8000);
    chk("add_ovf_psw", {28'b0, psw}, 32'hC);

    drive(9, 0, 16'hFFFF, 16'h0001, 16'h0000); step();
    chk("add_carry_psw", {28'b0, psw}, 32'h3);
    drive(10, 0, 16'h0000, 16'h0000, 16'h0001); step();
    chk("addc_psw", {28'b0, psw}, 32'h0);

    drive(9, 1, 16'h12FF, 16'h0001, 16'h1300); step();
    chk("byte_add_data", {16'b0, wb_data}, 32'h1200);
    chk("byte_add_psw", {28'b0, psw}, 32'h3);
    drive(14, 0, 16'h0005, 16'h0005, 16'h0000); step();
    chk("cmp_valid", {31'b0, wb_valid}, 32'h0);
    chk("cmp_psw", {28'b0, psw}, 32'h3);

    drive(0, 0, 16'h0, 16'h0, 16'h0); in_valid = 0; cc_set = 4'b1000; cc_clr = 4'b0001; step();
    chk("setcc_psw", {28'b0, psw}, 32'hA);
    drive(13, 0, 16'h9999, 16'h0001, 16'h0000); step();
    chk("dadd_psw", {28'b0, psw}, 32'hB);

    drive(16, 0, 16'hFFFF, 16'h8000, 16'h8000); cc_set = 4'b0001; cc_clr = 4'b1000; step();
    chk("cc_over_alu_psw", {28'b0, psw}, 32'h3);
    chk("cc_over_alu_valid", {31'b0, wb_valid}, 32'h1);
    psw_load = 1; psw_in = 4'b1010; step();
    chk("psw_load_psw", {28'b0, psw}, 32'hA);

    drive(17, 0, 16'h1234, 16'h4321, 16'h5335); step();
    drive(9, 0, 16'hAAAA, 16'h5555, 16'h0000); stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data", {16'b0, wb_data}, 32'h5335);
    end
    flush = 1; step();
    chk("flush_stall_valid", {31'b0, wb_valid}, 32'h0);

    drive(9, 0, 16'h0001, 16'h0001, 16'h0002); step();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk); #1 check_all();
    #2 rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      int ops[14] = '{9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 0, 3};
      set_op(ops[$urandom_range(0, 13)]);
      in_valid   = ($urandom_range(0, 3) != 0);
      byte_op    = $urandom_range(0, 1) == 1;
      a          = 16'($urandom);
      b          = 16'($urandom);
      alu_result = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      dst_in     = 3'($urandom);
      stall      = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      psw_load   = ($urandom_range(0, 15) == 0);
      psw_in     = 4'($urandom);
      cc_set     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      cc_clr     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute/writeback pipeline register directly downstream of the ALU.
- Captures the ALU result, destination index and write enable for the register-file writeback.
- Computes and holds the PSW condition flags V, N, Z, C.
- Drives the registered carry back to the ALU carry input for ADDC/SUBC/DADD.

Parameters:
- DATA_W, 16, datapath width. Only 16 is supported.
- REG_IDX_W, 3, register-file index width (R0–R7).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction in execute is valid this cycle.
- stall  in  1  hold all state this cycle.
- flush  in  1  squash the instruction in execute.
- enable  in  41  one-hot operation select, shared with the ALU. Bits used: 9 ADD, 10 ADDC, 11 SUB, 12 SUBC, 13 DADD, 14 CMP, 15 XOR, 16 AND, 17 OR, 18 BIT, 19 BIC, 20 BIS.
- byte_op  in  1  byte-width operation (flags from bit 7 and the low byte).
- a  in  16  ALU operand A (destination value).
- b  in  16  ALU operand B (source value).
- alu_result  in  16  combinational ALU result.
- dst_in  in  3  destination register index.
- psw_load  in  1  load the flags from psw_in (exception return).
- psw_in  in  4  {V,N,Z,C} value for psw_load.
- cc_set  in  4  SETCC mask {V,N,Z,C}.
- cc_clr  in  4  CLRCC mask {V,N,Z,C}.
- wb_valid  out  1  register-file write enable.
- wb_dst  out  3  write index.
- wb_data  out  16  write data.
- psw  out  4  registered flags {V,N,Z,C}.
- carry_out  out  1  equals psw[0]; connects to the ALU carry_in.

Behaviour:
- Reset (async, rst=1): wb_valid=0, wb_dst=0, wb_data=0, psw=4'b0000, carry_out=0. These values hold while rst is asserted. Reset mid-operation discards the in-flight instruction.
- Latency: 1 cycle. Inputs sampled at edge N appear on wb_* and psw after edge N.
- Update order at each edge, first matching case wins:
  1. flush=1: wb_valid<=0; psw unchanged. Applies even if stall=1.
  2. stall=1: all registers hold.
  3. Otherwise: evaluate the writeback rules and the PSW rules below.
- Writeback:
  - wb_valid <= in_valid and one of bits {9,10,11,12,13,15,16,17,19,20} is set. CMP (14) and BIT (18) never write.
  - wb_dst <= dst_in.
  - Word op: wb_data <= alu_result.
  - Byte op: wb_data <= {a[15:8], alu_result[7:0]}.
  - wb_dst and wb_data load whenever not stalled/flushed, even if in_valid=0.
- PSW priority, applied only when not stalled/flushed:
  1. psw_load=1: psw <= psw_in.
  2. Else cc_set or cc_clr nonzero (no in_valid needed): psw <= (psw & ~cc_clr) | cc_set. A bit set in both masks ends up 1. Any simultaneous ALU flag update is dropped.
  3. Else in_valid with an ALU op: update flags per the rules below.
  4. No op bit set: psw holds.
- Flag rules. Let W=8 if byte_op, else 16; m=W-1; r=alu_result masked to W bits.
  - Z = (r==0); N = r[m].
  - ADD/ADDC/SUB/SUBC/CMP: b' = b for ADD/ADDC, ~b for SUB/SUBC/CMP. cin = 0 (ADD), psw.C (ADDC, SUBC), 1 (SUB, CMP).
    - C = carry out of bit m of a + b' + cin. For subtraction, C=1 means no borrow.
    - V = (a[m]==b'[m]) && (r[m]!=a[m]).
  - DADD: C = decimal carry out of the top BCD digit (digit 1 for byte, digit 3 for word), computed per nibble: a digit sum >9 produces carry 1. V unchanged.
  - XOR/AND/OR/BIT/BIC/BIS: update Z and N only; C and V unchanged.
- carry_out is purely registered; no bypass. Back-to-back ADDC sees the carry from the previous instruction because that instruction's flags are written on the edge between the two.

Test Plan:
- Word ADD, a=0x7FFF, b=0x0001, alu_result=0x8000 -> wb_valid=1, wb_data=0x8000, psw {V,N,Z,C}=1100.
- ADD 0xFFFF+0x0001 (res 0x0000), then next cycle ADDC 0x0000+0x0000 -> first: psw=0011, carry_out=1; second: ALU returns 0x0001, psw=0000.
- Byte ADD, a=0x12FF, b=0x0001, alu_result=0x1300 -> wb_data=0x1200, psw=0011. Then CMP 0x0005 vs 0x0005 -> wb_valid=0, psw=0011.
- DADD word, a=0x9999, b=0x0001, cin=0, alu_result=0x0000 -> C=1, Z=1, N=0, V unchanged from prior value.
- Same edge: cc_set=0001, cc_clr=1000, plus a valid AND -> psw = (old & 0111) | 0001; AND's Z/N ignored; wb_valid=1. With psw_load=1 and psw_in=1010 also asserted -> psw=1010.
- Control:
  - stall for 3 cycles -> outputs frozen.
  - flush with stall=1 -> wb_valid=0 at the next edge.
  - rst pulsed mid-stream (not clock-aligned) -> all outputs 0 immediately.
